// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-access pipeline stage with an in-order response buffer.
// This stage sits between EX and WB. Up to DEPTH instructions can be held at once.
// A load finishes when its in-order data_ok response arrives.
// Responses owed to flushed loads are counted and dropped.
// Load data is aligned and extended here, and the youngest entry is forwarded to ID/EX.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid/in_allowin  EX handshake; an accepted load issues its SRAM request that cycle
//   in_is_load, in_op, in_addr_lo, in_rt, in_alu_result,
//   in_gr_we, in_dest, in_pc, in_ex       incoming instruction fields
//   data_ok, data_rdata  one in-order SRAM response per cycle
//   flush                exception/eret from WB; empties the stage
//   out_valid/out_allowin WB handshake for the head entry
//   out_gr_we, out_dest, out_result, out_pc, out_ex   head entry fields
//   fwd_valid, fwd_dest, fwd_ready, fwd_value         youngest entry forwarding
//   occupancy            number of valid entries
module mem_resp_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_allowin,
    input  logic             in_is_load,
    input  logic [2:0]       in_op,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_rt,
    input  logic [31:0]      in_alu_result,
    input  logic             in_gr_we,
    input  logic [4:0]       in_dest,
    input  logic [31:0]      in_pc,
    input  logic             in_ex,
    input  logic             data_ok,
    input  logic [31:0]      data_rdata,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_allowin,
    output logic             out_gr_we,
    output logic [4:0]       out_dest,
    output logic [31:0]      out_result,
    output logic [31:0]      out_pc,
    output logic             out_ex,
    output logic             fwd_valid,
    output logic [4:0]       fwd_dest,
    output logic             fwd_ready,
    output logic [31:0]      fwd_value,
    output logic [CNT_W-1:0] occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LWL = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;

    // Entry storage
    logic        e_valid    [DEPTH];
    logic        e_got      [DEPTH];
    logic        e_is_load  [DEPTH];
    logic [2:0]  e_op       [DEPTH];
    logic [1:0]  e_addr_lo  [DEPTH];
    logic [31:0] e_rt       [DEPTH];
    logic [31:0] e_alu      [DEPTH];
    logic        e_gr_we    [DEPTH];
    logic [4:0]  e_dest     [DEPTH];
    logic [31:0] e_pc       [DEPTH];
    logic        e_ex       [DEPTH];
    logic [31:0] e_data     [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] discard;

    logic [PTR_W-1:0] tgt_idx;
    logic             tgt_found;
    logic [CNT_W-1:0] pending;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] yng_idx;
    logic             discard_zero;
    logic             resp_drop;
    logic             resp_hit;
    logic             retire;
    logic             retire_eff;
    logic             accept;
    logic [SUM_W-1:0] inflight_after;
    logic [SUM_W-1:0] flush_discard;
    logic [31:0]      head_data;
    logic [31:0]      yng_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Align and extend load data; reserved op 111 behaves as lw
    function automatic logic [31:0] load_extract(
        input logic [2:0]  op,
        input logic [1:0]  lo,
        input logic [31:0] rt,
        input logic [31:0] d
    );
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lo[1] ? d[31:16] : d[15:0];
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        case (op)
            OP_LH:  r = {{16{h[15]}}, h};
            OP_LHU: r = {16'h0000, h};
            OP_LB:  r = {{24{b[7]}}, b};
            OP_LBU: r = {24'h000000, b};
            OP_LWL: begin
                case (lo)
                    2'd0:    r = {d[7:0],  rt[23:0]};
                    2'd1:    r = {d[15:0], rt[15:0]};
                    2'd2:    r = {d[23:0], rt[7:0]};
                    default: r = d;
                endcase
            end
            OP_LWR: begin
                case (lo)
                    2'd0:    r = d;
                    2'd1:    r = {rt[31:24], d[31:8]};
                    2'd2:    r = {rt[31:16], d[31:16]};
                    default: r = {rt[31:8],  d[31:24]};
                endcase
            end
            OP_LW:   r = d;
            default: r = d;
        endcase
        return r;
    endfunction

    // Oldest load still waiting for data, and count of all waiting loads
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = head;
        pending   = '0;
        scan_idx  = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (e_valid[scan_idx] && e_is_load[scan_idx] && !e_got[scan_idx]) begin
                if (!tgt_found) begin
                    tgt_found = 1'b1;
                    tgt_idx   = scan_idx;
                end
                pending = pending + CNT_W'(1);
            end
            scan_idx = ptr_inc(scan_idx);
        end
    end

    assign yng_idx      = (tail == '0) ? PTR_W'(DEPTH - 1) : tail - PTR_W'(1);
    assign discard_zero = (discard == '0);
    assign resp_drop    = data_ok && !discard_zero;
    assign resp_hit     = data_ok && discard_zero && tgt_found;

    // Head entry; a response landing on it this cycle bypasses straight to out_result
    assign head_data  = e_got[head] ? e_data[head] : data_rdata;
    assign out_valid  = e_valid[head] &&
                        (!e_is_load[head] || e_got[head] || (resp_hit && tgt_idx == head));
    assign out_result = e_is_load[head] ?
                        load_extract(e_op[head], e_addr_lo[head], e_rt[head], head_data) :
                        e_alu[head];
    assign out_gr_we  = e_gr_we[head];
    assign out_dest   = e_dest[head];
    assign out_pc     = e_pc[head];
    assign out_ex     = e_ex[head];

    // Youngest entry forwarding
    assign yng_data   = e_got[yng_idx] ? e_data[yng_idx] : data_rdata;
    assign fwd_valid  = (occ != '0) && e_valid[yng_idx] && e_gr_we[yng_idx];
    assign fwd_dest   = e_dest[yng_idx];
    assign fwd_ready  = !e_is_load[yng_idx] || e_got[yng_idx] ||
                        (resp_hit && tgt_idx == yng_idx);
    assign fwd_value  = e_is_load[yng_idx] ?
                        load_extract(e_op[yng_idx], e_addr_lo[yng_idx], e_rt[yng_idx], yng_data) :
                        e_alu[yng_idx];

    // Handshakes; the in-flight bound counts loads owed to flushed entries too
    assign retire         = out_valid && out_allowin;
    assign retire_eff     = retire && !flush;
    assign inflight_after = SUM_W'(occ) - SUM_W'(retire) + SUM_W'(discard);
    assign in_allowin     = !flush &&
                            ((SUM_W'(occ) < SUM_W'(DEPTH)) || retire) &&
                            (inflight_after < SUM_W'(DEPTH));
    assign accept         = in_valid && in_allowin;

    // A response during flush is consumed either by an old discard or by a flushed entry
    assign flush_discard  = SUM_W'(discard) + SUM_W'(pending) -
                            SUM_W'(data_ok && (!discard_zero || tgt_found));

    assign occupancy = occ;

    // Control state: validity, response tracking, pointers and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            discard <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                e_valid[k] <= 1'b0;
                e_got[k]   <= 1'b0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            discard <= CNT_W'(flush_discard);
            for (int unsigned k = 0; k < DEPTH; k++) begin
                e_valid[k] <= 1'b0;
                e_got[k]   <= 1'b0;
            end
        end else begin
            if (resp_drop) begin
                discard <= discard - CNT_W'(1);
            end
            if (retire_eff) begin
                e_valid[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            if (resp_hit) begin
                e_got[tgt_idx] <= 1'b1;
            end
            // Accept last: when full, the slot freed by retire is reused this edge
            if (accept) begin
                e_valid[tail] <= 1'b1;
                e_got[tail]   <= 1'b0;
                tail          <= ptr_inc(tail);
            end
            occ <= occ + CNT_W'(accept) - CNT_W'(retire_eff);
        end
    end

    // Payload storage, qualified by the control state above
    always_ff @(posedge clk) begin
        if (resp_hit) begin
            e_data[tgt_idx] <= data_rdata;
        end
        if (accept) begin
            e_is_load[tail] <= in_is_load && !in_ex;
            e_op[tail]      <= in_op;
            e_addr_lo[tail] <= in_addr_lo;
            e_rt[tail]      <= in_rt;
            e_alu[tail]     <= in_alu_result;
            e_gr_we[tail]   <= in_gr_we;
            e_dest[tail]    <= in_dest;
            e_pc[tail]      <= in_pc;
            e_ex[tail]      <= in_ex;
        end
    end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed testbench for mem_resp_stage (DEPTH=2).
module tb_mem_resp_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_allowin;
    logic        in_is_load;
    logic [2:0]  in_op;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_rt;
    logic [31:0] in_alu_result;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic [31:0] in_pc;
    logic        in_ex;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        out_valid;
    logic        out_allowin;
    logic        out_gr_we;
    logic [4:0]  out_dest;
    logic [31:0] out_result;
    logic [31:0] out_pc;
    logic        out_ex;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic        fwd_ready;
    logic [31:0] fwd_value;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp_stage #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_is_load(in_is_load),
        .in_op(in_op), .in_addr_lo(in_addr_lo), .in_rt(in_rt),
        .in_alu_result(in_alu_result), .in_gr_we(in_gr_we), .in_dest(in_dest),
        .in_pc(in_pc), .in_ex(in_ex),
        .data_ok(data_ok), .data_rdata(data_rdata), .flush(flush),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_gr_we(out_gr_we),
        .out_dest(out_dest), .out_result(out_result), .out_pc(out_pc), .out_ex(out_ex),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready),
        .fwd_value(fwd_value), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_is_load = 0; in_op = 0; in_addr_lo = 0; in_rt = 0;
        in_alu_result = 0; in_gr_we = 0; in_dest = 0; in_pc = 0; in_ex = 0;
        data_ok = 0; data_rdata = 0; flush = 0;
    endtask

    task automatic issue_load(input logic [2:0] op, input logic [1:0] lo,
                              input logic [31:0] rt, input logic [4:0] dest);
        in_valid = 1; in_is_load = 1; in_op = op; in_addr_lo = lo; in_rt = rt;
        in_gr_we = 1; in_dest = dest; in_pc = 32'h0000_0100 + 32'(dest);
        tick();
        in_valid = 0; in_is_load = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle(); out_allowin = 1;
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %0b exp 0", fwd_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (in_allowin !== 1'b1) begin errors++; $display("FAIL reset_in_allowin got %0b exp 1", in_allowin); end
    endtask

    task automatic test_lh();
        issue_load(3'b001, 2'd2, 32'h0, 5'd3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lh_wait_valid got %0b exp 0", out_valid); end
        checks++; if (fwd_valid !== 1'b1 || fwd_dest !== 5'd3 || fwd_ready !== 1'b0) begin
            errors++; $display("FAIL lh_fwd_pending got v%0b d%0d r%0b exp v1 d3 r0", fwd_valid, fwd_dest, fwd_ready); end
        tick(); tick();
        data_ok = 1; data_rdata = 32'h8001_1234;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lh_valid got %0b exp 1", out_valid); end
        checks++; if (out_result !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_result got %h exp ffff8001", out_result); end
        checks++; if (out_gr_we !== 1'b1 || out_dest !== 5'd3) begin errors++; $display("FAIL lh_fields got we%0b d%0d exp we1 d3", out_gr_we, out_dest); end
        checks++; if (fwd_ready !== 1'b1 || fwd_value !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh_fwd_bypass got r%0b %h exp r1 ffff8001", fwd_ready, fwd_value); end
        tick(); data_ok = 0; #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL lh_drain got %0d exp 0", occupancy); end
        issue_load(3'b010, 2'd2, 32'h0, 5'd3);
        data_ok = 1; data_rdata = 32'h8001_1234;
        #1;
        checks++; if (out_result !== 32'h0000_8001) begin errors++; $display("FAIL lhu_result got %h exp 00008001", out_result); end
        tick(); data_ok = 0; #1;
    endtask

    task automatic test_lwl_lwr();
        issue_load(3'b101, 2'd1, 32'hAABB_CCDD, 5'd4);
        data_ok = 1; data_rdata = 32'h1122_3344; #1;
        checks++; if (out_result !== 32'h3344_CCDD) begin errors++; $display("FAIL lwl_result got %h exp 3344ccdd", out_result); end
        tick(); data_ok = 0; #1;
        issue_load(3'b110, 2'd1, 32'hAABB_CCDD, 5'd4);
        data_ok = 1; data_rdata = 32'h1122_3344; #1;
        checks++; if (out_result !== 32'hAA11_2233) begin errors++; $display("FAIL lwr_result got %h exp aa112233", out_result); end
        tick(); data_ok = 0; #1;
    endtask

    task automatic test_byte();
        issue_load(3'b011, 2'd3, 32'h0, 5'd6);
        data_ok = 1; data_rdata = 32'h8A00_0000; #1;
        checks++; if (out_result !== 32'hFFFF_FF8A) begin errors++; $display("FAIL lb_result got %h exp ffffff8a", out_result); end
        tick(); data_ok = 0; #1;
        issue_load(3'b100, 2'd0, 32'h0, 5'd6);
        data_ok = 1; data_rdata = 32'h0000_00F0; #1;
        checks++; if (out_result !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_result got %h exp 000000f0", out_result); end
        tick(); data_ok = 0; #1;
    endtask

    task automatic test_ex();
        in_valid = 1; in_is_load = 1; in_ex = 1; in_alu_result = 32'hABCD_0001;
        in_gr_we = 1; in_dest = 5'd9;
        tick();
        in_valid = 0; in_is_load = 0; in_ex = 0; #1;
        checks++; if (out_valid !== 1'b1 || out_ex !== 1'b1) begin errors++; $display("FAIL ex_valid got v%0b ex%0b exp v1 ex1", out_valid, out_ex); end
        checks++; if (out_result !== 32'hABCD_0001) begin errors++; $display("FAIL ex_result got %h exp abcd0001", out_result); end
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL ex_drain got %0d exp 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        out_allowin = 0;
        issue_load(3'b000, 2'd0, 32'h0, 5'd1);
        issue_load(3'b000, 2'd0, 32'h0, 5'd2);
        checks++; if (occupancy !== 2'd2 || in_allowin !== 1'b0) begin
            errors++; $display("FAIL b2b_full got occ%0d allow%0b exp occ2 allow0", occupancy, in_allowin); end
        data_ok = 1; data_rdata = 32'h1; #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h1 || in_allowin !== 1'b0) begin
            errors++; $display("FAIL b2b_first got v%0b %h allow%0b exp v1 1 allow0", out_valid, out_result, in_allowin); end
        tick();
        data_rdata = 32'h2;
        tick();
        data_ok = 0; #1;
        checks++; if (out_result !== 32'h1 || out_dest !== 5'd1) begin
            errors++; $display("FAIL b2b_head got %h d%0d exp 1 d1", out_result, out_dest); end
        out_allowin = 1; #1;
        checks++; if (in_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allow_on_retire got %0b exp 1", in_allowin); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h2 || out_dest !== 5'd2) begin
            errors++; $display("FAIL b2b_second got v%0b %h d%0d exp v1 2 d2", out_valid, out_result, out_dest); end
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        out_allowin = 0;
        issue_load(3'b000, 2'd0, 32'h0, 5'd1);
        issue_load(3'b000, 2'd0, 32'h0, 5'd2);
        flush = 1; #1;
        checks++; if (in_allowin !== 1'b0) begin errors++; $display("FAIL flush_allow got %0b exp 0", in_allowin); end
        tick();
        flush = 0; #1;
        checks++; if (occupancy !== 2'd0 || in_allowin !== 1'b0) begin
            errors++; $display("FAIL flush_after got occ%0d allow%0b exp occ0 allow0", occupancy, in_allowin); end
        data_ok = 1; data_rdata = 32'hDEAD_0001; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop1 got %0b exp 0", out_valid); end
        tick();
        data_ok = 0;
        in_valid = 1; in_is_load = 1; in_op = 3'b000; in_gr_we = 1; in_dest = 5'd6; #1;
        checks++; if (in_allowin !== 1'b1) begin errors++; $display("FAIL flush_allow_one got %0b exp 1", in_allowin); end
        tick();
        in_valid = 0; in_is_load = 0;
        data_ok = 1; data_rdata = 32'hDEAD_0002; #1;
        checks++; if (in_allowin !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop2 got allow%0b v%0b exp allow0 v0", in_allowin, out_valid); end
        tick();
        data_rdata = 32'h0000_0055; #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0055) begin
            errors++; $display("FAIL flush_new_load got v%0b %h exp v1 00000055", out_valid, out_result); end
        out_allowin = 1;
        tick();
        data_ok = 0; #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_drain got %0d exp 0", occupancy); end
    endtask

    task automatic test_stall();
        out_allowin = 0;
        in_valid = 1; in_is_load = 0; in_alu_result = 32'h1234_5678; in_gr_we = 1;
        in_dest = 5'd7; in_pc = 32'h0000_0200;
        tick();
        in_valid = 0; #1;
        issue_load(3'b000, 2'd0, 32'h0, 5'd5);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234_5678 || out_dest !== 5'd7 || out_pc !== 32'h0000_0200) begin
                errors++; $display("FAIL stall_hold[%0d] got v%0b %h d%0d pc%h exp v1 12345678 d7 pc00000200", i, out_valid, out_result, out_dest, out_pc); end
            checks++; if (fwd_valid !== 1'b1 || fwd_dest !== 5'd5 || fwd_ready !== 1'b0) begin
                errors++; $display("FAIL stall_fwd[%0d] got v%0b d%0d r%0b exp v1 d5 r0", i, fwd_valid, fwd_dest, fwd_ready); end
            tick();
        end
        data_ok = 1; data_rdata = 32'hCAFE_BABE; #1;
        checks++; if (fwd_ready !== 1'b1 || fwd_value !== 32'hCAFE_BABE) begin
            errors++; $display("FAIL stall_fwd_ready got r%0b %h exp r1 cafebabe", fwd_ready, fwd_value); end
        checks++; if (out_result !== 32'h1234_5678) begin errors++; $display("FAIL stall_head_keep got %h exp 12345678", out_result); end
        tick();
        data_ok = 0; out_allowin = 1;
        tick(); tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush_data_ok();
        out_allowin = 0;
        issue_load(3'b000, 2'd0, 32'h0, 5'd1);
        issue_load(3'b000, 2'd0, 32'h0, 5'd2);
        flush = 1; data_ok = 1; data_rdata = 32'h0000_0011;
        tick();
        flush = 0; data_ok = 0;
        in_valid = 1; in_is_load = 1; in_op = 3'b000; in_gr_we = 1; in_dest = 5'd8; #1;
        checks++; if (in_allowin !== 1'b1) begin errors++; $display("FAIL fdo_allow got %0b exp 1", in_allowin); end
        tick();
        in_valid = 0; in_is_load = 0;
        data_ok = 1; data_rdata = 32'h0000_0022; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fdo_drop got %0b exp 0", out_valid); end
        tick();
        data_rdata = 32'h0000_0077; #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0077) begin
            errors++; $display("FAIL fdo_new_load got v%0b %h exp v1 00000077", out_valid, out_result); end
        out_allowin = 1;
        tick();
        data_ok = 0; #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fdo_drain got %0d exp 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_lh();
        test_lwl_lwr();
        test_byte();
        test_ex();
        test_back_to_back();
        test_flush();
        test_stall();
        test_flush_data_ok();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
